// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the parametrised UART.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OS_RATE    = 16;
  localparam int unsigned MID_SAMPLE = 8;
  localparam int unsigned CNT_W      = $clog2(OS_RATE);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversampling tick generator: os_tick pulses once every
// DIV = CLK_FREQ/(BAUD*16) clocks (DIV=1 gives a tick on every clock).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic clk_50m,
  input  logic rst,
  output logic os_tick
);

  localparam int DIV   = CLK_FREQ / (BAUD * int'(OS_RATE));
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_gen: CLK_FREQ/(BAUD*16) must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      div_cnt <= '0;
      os_tick <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      os_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised UART (TX + RX) sharing one 16x baud generator.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  input  logic                 rx_ready_clr,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_core_param: illegal DATA_BITS, STOP_BITS or PARITY_ODD");
  end

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OS_RATE - 1);
  localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(MID_SAMPLE - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic             PAR_ODD   = 1'(PARITY_ODD);
`endif

  logic os_tick;

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (
    .clk_50m (clk_50m),
    .rst     (rst),
    .os_tick (os_tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t              tx_state, tx_state_n;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_n;
  logic [3:0]             tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0]   tx_sh, tx_sh_n;
  logic                   tx_q, tx_n;
  logic                   tx_par, tx_par_n;
  logic                   tx_bit_end;

  assign tx_bit_end = os_tick && (tx_cnt == LAST_TICK);
  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx         = tx_q;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_q     <= tx_n;
      tx_par   <= tx_par_n;
    end
  end

  // tx is registered: the next line level is chosen together with the next state
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_n       = tx_q;
    tx_par_n   = tx_par;
    if (os_tick && tx_state != TX_IDLE) tx_cnt_n = tx_cnt + 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (tx_start) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_sh_n    = tx_data;
          tx_n       = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_n   = ^tx_data ^ PAR_ODD;
`endif
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_n       = tx_sh[0];
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit == LAST_BIT) begin
          tx_bit_n = '0;
`ifdef UART_PARITY_EN
          tx_state_n = TX_PARITY;
          tx_n       = tx_par;
`else
          tx_state_n = TX_STOP;
          tx_n       = 1'b1;
`endif
        end else begin
          tx_bit_n = tx_bit + 1'b1;
          tx_sh_n  = tx_sh >> 1;
          tx_n     = tx_sh[1];
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) begin
        tx_state_n = TX_STOP;
        tx_n       = 1'b1;
      end
`endif
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit == LAST_STOP) tx_state_n = TX_IDLE;
        else                     tx_bit_n   = tx_bit + 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t              rx_state, rx_state_n;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_n;
  logic [3:0]             rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0]   rx_sh, rx_sh_n;
  logic                   rx_par, rx_par_n;
  logic                   rx_s1, rx_s2, rx_prev;
  logic                   rx_fall, rx_bit_end, rx_done, rx_stop_ok, rx_mismatch;

  assign rx_fall    = rx_prev && !rx_s2;
  assign rx_bit_end = os_tick && (rx_cnt == LAST_TICK);
`ifdef UART_PARITY_EN
  assign rx_mismatch = ^rx_sh ^ rx_par ^ PAR_ODD;
`else
  assign rx_mismatch = 1'b0;
`endif

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_par   <= rx_par_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_par_n   = rx_par;
    rx_done    = 1'b0;
    rx_stop_ok = 1'b1;
    if (os_tick && rx_state != RX_IDLE) rx_cnt_n = rx_cnt + 1'b1;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      RX_START: if (os_tick && rx_cnt == MID_TICK) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
        rx_bit_n = rx_bit + 1'b1;
`ifdef UART_PARITY_EN
        if (rx_bit == LAST_BIT) rx_state_n = RX_PARITY;
`else
        if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_bit_end) begin
        rx_par_n   = rx_s2;
        rx_state_n = RX_STOP;
      end
`endif
      RX_STOP: if (rx_bit_end) begin
        rx_done    = 1'b1;
        rx_stop_ok = rx_s2;
        rx_state_n = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s2) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
    if (!rx_en) rx_state_n = RX_IDLE;
  end

  // a same-cycle clear frees the holding register for the arriving word
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (rx_done) begin
      if (!rx_ready || rx_ready_clr) begin
        rx_data       <= rx_sh;
        rx_ready      <= 1'b1;
        rx_frame_err  <= !rx_stop_ok;
        rx_parity_err <= rx_mismatch;
        if (rx_ready_clr) rx_overrun <= 1'b0;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_ready_clr) begin
      rx_ready      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param at DIV=1 (one bit = 16 clocks).
// Define UART_PARITY_EN for the even-parity build and its extra checks.
module tb_uart_core_param;

`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB        = 10 + PAR;
  localparam int FRAME_CYC = 16 * FB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_line;
  logic       rx_en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ready, rx_ready_clr = 1'b0;
  logic       rx_frame_err, rx_parity_err, rx_overrun;

  int n_checks = 0;
  int n_errors = 0;

  assign rx_line = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_param #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk_50m       (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .tx            (tx),
    .rx            (rx_line),
    .rx_en         (rx_en),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_ready_clr  (rx_ready_clr),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // start/stop plus even parity (when built) around a data byte, LSB first
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
    mk_frame = {1'b1, stop, ^d, d, 1'b0};
`else
    mk_frame = {2'b11, stop, d, 1'b0};
`endif
  endfunction

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic drive_bits(input logic [11:0] bits, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 rx_ready_clr = 1'b1;
    @(posedge clk); #1 rx_ready_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rx_ready) break;
    end
    check("ready_wait", rx_ready, 1);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    check("busy_wait", tx_busy, 0);
  endtask

  initial begin
    logic [7:0] pat;
    logic       exp_tx;
    int         b;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", rx_ready, 0);
    check("rst_data", rx_data, 0);
    check("rst_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);

    // 1: TX waveform of 0xA5, plus an ignored tx_start while busy
    pat = 8'hA5;
    send(pat);
    for (int c = 1; c <= FRAME_CYC + 10; c++) begin
      @(negedge clk);
      b = (c - 1) / 16;
      if (c > FRAME_CYC)             exp_tx = 1'b1;
      else if (b == 0)               exp_tx = 1'b0;
      else if (b <= 8)               exp_tx = pat[b-1];
      else if (PAR == 1 && b == 9)   exp_tx = ^pat;
      else                           exp_tx = 1'b1;
      check("tx_wave", tx, exp_tx);
      check("tx_busy", tx_busy, (c <= FRAME_CYC) ? 1 : 0);
      if (c == 50) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end
      if (c == 51) tx_start = 1'b0;
    end

    // 2: loopback 0x3C
    loop = 1'b1;
    send(8'h3C);
    wait_ready(400);
    check("lb_data", rx_data, 8'h3C);
    check("lb_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    wait_idle(400);
    pulse_clr();
    check("lb_clr", rx_ready, 0);

    // 3: overrun keeps the first word
    send(8'h11);
    wait_idle(400);
    send(8'h22);
    wait_idle(400);
    repeat (5) @(negedge clk);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_ready", rx_ready, 1);
    check("ovr_flag", rx_overrun, 1);
    pulse_clr();
    check("ovr_clr", {rx_ready, rx_frame_err, rx_parity_err, rx_overrun}, 0);

    // 4: framing error, then rx held low (break) for 400 cycles
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    drive_bits(mk_frame(8'h55, 1'b0), FB);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 20) begin
        check("fe_ready", rx_ready, 1);
        check("fe_flag", rx_frame_err, 1);
        check("fe_data", rx_data, 8'h55);
        rx_ready_clr = 1'b1;
      end
      if (i == 21) rx_ready_clr = 1'b0;
    end
    check("brk_ready", rx_ready, 0);
    check("brk_fe", rx_frame_err, 0);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("brk_release", rx_ready, 0);
    drive_bits(mk_frame(8'h81, 1'b1), FB);
    repeat (4) @(negedge clk);
    check("post_brk_ready", rx_ready, 1);
    check("post_brk_data", rx_data, 8'h81);
    check("post_brk_fe", rx_frame_err, 0);
    pulse_clr();

    // 5a: 4-cycle start glitch is rejected
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_ready", rx_ready, 0);
    check("glitch_fe", rx_frame_err, 0);

`ifdef UART_PARITY_EN
    // 6: even parity on 0x07 needs parity bit 1
    drive_bits({2'b11, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check("par_bad_ready", rx_ready, 1);
    check("par_bad_data", rx_data, 8'h07);
    check("par_bad_flag", rx_parity_err, 1);
    pulse_clr();
    check("par_clr", rx_parity_err, 0);
    drive_bits({2'b11, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check("par_ok_ready", rx_ready, 1);
    check("par_ok_flag", rx_parity_err, 0);
`endif

    // 5b: reset mid-TX
    send(8'hA5);
    repeat (50) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_tx", tx, 1);
    check("mrst_busy", tx_busy, 0);
    check("mrst_data", rx_data, 0);
    check("mrst_ready", rx_ready, 0);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
